alu_issue_stage: RTL

//  Upstream issue stage for the combinational alu. Accepts {a, b, mode} operations over a

---
 rtl/alu_pkg.sv | 11 +
 rtl/alu_issue_stage_if.sv | 24 ++
 rtl/alu.sv | 23 ++
 rtl/alu_op_fifo.sv | 54 +++++
 rtl/alu_issue_stage.sv | 85 ++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding used by the alu, the issue stage and its bench.
package alu_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } alu_mode_e;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Upstream op handshake and downstream result handshake of the alu issue stage.
interface alu_issue_stage_if #(
  parameter int DATA_WIDTH = 8
);
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_a;
  logic [DATA_WIDTH-1:0]  in_b;
  alu_pkg::alu_mode_e     in_mode;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_result;
  alu_pkg::alu_mode_e     out_mode;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_result, out_mode
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_result, out_mode
  );
endinterface

// File: rtl/alu.sv
// Combinational alu; results wrap modulo 2^DATA_WIDTH with no carry/borrow out.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  alu_mode_e             mode,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = '0;
    case (mode)
      ADD:     result = a + b;
      SUB:     result = a - b;
      AND:     result = a & b;
      default: result = a | b;
    endcase
  end

endmodule

// File: rtl/alu_op_fifo.sv
// Synchronous op FIFO; head is the entry at rd_ptr, count spans 0..DEPTH inclusive.
module alu_op_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // pointer/count control
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // storage is data only, never reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: buffers ops, drives the FIFO head into an external alu, registers its result.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  alu_issue_stage_if.slave         bus,
  output logic [DATA_WIDTH-1:0]    alu_a,
  output logic [DATA_WIDTH-1:0]    alu_b,
  output alu_mode_e                alu_mode,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int EW = 2 * DATA_WIDTH + 2;

  logic                  ready_en;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;
  logic [EW-1:0]         head;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] res_p1;
  alu_mode_e             mode_p1;

  // ready_en holds in_ready low until the first edge after reset releases
  assign bus.in_ready = ready_en & ~full;
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = ~empty & (~vld_p1 | bus.out_ready);

  alu_op_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data ({bus.in_mode, bus.in_a, bus.in_b}),
    .head    (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // p0: FIFO head onto the alu, parked at 0/0/ADD while empty
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_mode = ADD;
    if (!empty) begin
      alu_mode = alu_mode_e'(head[EW-1 -: 2]);
      alu_a    = head[2*DATA_WIDTH-1 -: DATA_WIDTH];
      alu_b    = head[DATA_WIDTH-1:0];
    end
  end

  // p1: output register, captured whenever the slot is free or being drained
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_en <= 1'b0;
      vld_p1   <= 1'b0;
      res_p1   <= '0;
      mode_p1  <= ADD;
    end else begin
      ready_en <= 1'b1;
      if (pop) begin
        res_p1  <= alu_result;
        mode_p1 <= alu_mode;
        vld_p1  <= 1'b1;
      end else if (vld_p1 && bus.out_ready) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = vld_p1;
  assign bus.out_result = res_p1;
  assign bus.out_mode   = mode_p1;

endmodule
